// File: rtl/grid_row_scanner_if.sv
// Grid hand-off between the Game-of-Life core and the row scanner.
// The core drives a new generation with a strobe and sees whether one is queued.
interface grid_row_scanner_if;
   logic [63:0] grid_in;
   logic        grid_valid;
   logic        pending;

   modport master (
      output grid_in,
      output grid_valid,
      input  pending
   );

   modport slave (
      input  grid_in,
      input  grid_valid,
      output pending
   );
endinterface

// File: rtl/grid_row_scanner.sv
// Double-buffered 8x8 LED matrix row scanner with per-row blanking.
// A new grid is shown only from a frame boundary, or at once while dark.
module grid_row_scanner #(
   parameter int DWELL          = 1000,
   parameter int BLANK          = 50,
   parameter bit ROW_ACTIVE_LOW = 1'b0,
   parameter bit COL_ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   grid_row_scanner_if.slave gif,
   output logic [7:0]        row_sel,
   output logic [7:0]        col_out,
   output logic [2:0]        row_idx,
   output logic              frame_done
);

   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic {
      ST_BLANK,
      ST_DRIVE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    row_q, row_d;
   logic [63:0]   disp_q, disp_d;
   logic [63:0]   pbuf_q, pbuf_d;
   logic          pend_q, pend_d;
   logic          fdone_q, fdone_d;

   logic          last_blank;
   logic          last_dwell;
   logic          boundary;
   logic          xfer;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      row_d      = row_q;
      disp_d     = disp_q;
      pbuf_d     = pbuf_q;
      pend_d     = pend_q;
      last_blank = (cnt_q == CW'(BLANK - 1));
      last_dwell = (cnt_q == CW'(DWELL - 1));
      boundary   = enable && (state_q == ST_DRIVE)
                   && last_dwell && (row_q == 3'd7);
      // While dark there is nothing to tear, so every cycle is a boundary.
      xfer       = !enable || boundary;
      fdone_d    = boundary;

      if (!enable) begin
         state_d = ST_BLANK;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_BLANK: begin
               if (last_blank) begin
                  state_d = ST_DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_DRIVE: begin
               if (last_dwell) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  row_d   = row_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
            end
         endcase
      end

      if (gif.grid_valid) begin
         pbuf_d = gif.grid_in;
      end

      if (xfer) begin
         if (gif.grid_valid) begin
            disp_d = gif.grid_in;
         end else if (pend_q) begin
            disp_d = pbuf_q;
         end
         pend_d = 1'b0;
      end else if (gif.grid_valid) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         row_q   <= 3'd0;
         disp_q  <= '0;
         pbuf_q  <= '0;
         pend_q  <= 1'b0;
         fdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         disp_q  <= disp_d;
         pbuf_q  <= pbuf_d;
         pend_q  <= pend_d;
         fdone_q <= fdone_d;
      end
   end

   logic       drive_on;
   logic [7:0] rs;
   logic [7:0] cs;

   always_comb begin
      drive_on = enable && !reset;
      rs       = drive_on ? (8'd1 << row_q) : 8'd0;
      cs       = 8'd0;
      if (drive_on && (state_q == ST_DRIVE)) begin
         cs = disp_q[{row_q, 3'b000} +: 8];
      end
   end

   assign row_sel     = ROW_ACTIVE_LOW ? ~rs : rs;
   assign col_out     = COL_ACTIVE_LOW ? ~cs : cs;
   assign row_idx     = row_q;
   assign frame_done  = fdone_q;
   assign gif.pending = pend_q;

endmodule

// File: tb/tb_grid_row_scanner.sv
// Directed bench for grid_row_scanner with DWELL=4, BLANK=2 (48-cycle frame).
// cyc tracks the cycle number since the last reset release or row re-sync.
module tb_grid_row_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] row_sel;
   logic [7:0] col_out;
   logic [2:0] row_idx;
   logic       frame_done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #10 clk = ~clk;

   grid_row_scanner_if gif ();

   grid_row_scanner #(
      .DWELL(4),
      .BLANK(2),
      .ROW_ACTIVE_LOW(1'b0),
      .COL_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .gif(gif),
      .row_sel(row_sel),
      .col_out(col_out),
      .row_idx(row_idx),
      .frame_done(frame_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto_pos(input int p);
      for (int i = 0; i < 50 && (cyc % 48) != p; i++) step();
   endtask

   task automatic strobe(input logic [63:0] g);
      gif.grid_in    = g;
      gif.grid_valid = 1'b1;
      step();
      gif.grid_valid = 1'b0;
      gif.grid_in    = '0;
   endtask

   task automatic test_reset();
      logic bad;
      reset = 1'b1; enable = 1'b1;
      gif.grid_valid = 1'b0; gif.grid_in = '0;
      step(); step();
      checks++;
      if ({row_idx, row_sel, col_out, gif.pending, frame_done} !== 21'h0) begin
         failures++;
         $display("FAIL reset_state got=%h exp=0",
                  {row_idx, row_sel, col_out, gif.pending, frame_done});
      end
      reset = 1'b0; #1; cyc = 0;
      bad = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (row_sel !== 8'h01 || col_out !== 8'h00) bad = 1'b1;
         step();
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL blank_phase got=%h/%h exp=01/00", row_sel, col_out);
      end
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (row_sel !== 8'h01 || col_out !== 8'h00 || row_idx !== 3'd0) bad = 1'b1;
         step();
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL drive_phase got=%h/%h exp=01/00", row_sel, col_out);
      end
      checks++;
      if (row_idx !== 3'd1 || row_sel !== 8'h02) begin
         failures++;
         $display("FAIL row1_at_cyc6 got=%0d/%h exp=1/02", row_idx, row_sel);
      end
   endtask

   task automatic test_frame_done();
      logic early;
      early = 1'b0;
      while (cyc < 48) begin
         if (frame_done !== 1'b0) early = 1'b1;
         step();
      end
      checks++;
      if (early) begin
         failures++;
         $display("FAIL frame_done_early got=1 exp=0");
      end
      checks++;
      if (frame_done !== 1'b1 || row_idx !== 3'd0) begin
         failures++;
         $display("FAIL frame_done_48 got=%b/%0d exp=1/0", frame_done, row_idx);
      end
      step();
      checks++;
      if (frame_done !== 1'b0) begin
         failures++;
         $display("FAIL frame_done_width got=%b exp=0", frame_done);
      end
   endtask

   task automatic test_midframe();
      logic bad;
      goto_pos(10);
      strobe(64'h8100_0000_0000_00FF);
      checks++;
      if (gif.pending !== 1'b1 || col_out !== 8'h00) begin
         failures++;
         $display("FAIL mid_capture got=%b/%h exp=1/00", gif.pending, col_out);
      end
      bad = 1'b0;
      while ((cyc % 48) != 0) begin
         if (col_out !== 8'h00 || gif.pending !== 1'b1) bad = 1'b1;
         step();
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL no_tearing got=%h exp=00", col_out);
      end
      checks++;
      if (gif.pending !== 1'b0 || frame_done !== 1'b1) begin
         failures++;
         $display("FAIL mid_transfer got=%b/%b exp=0/1", gif.pending, frame_done);
      end
      goto_pos(2);
      checks++;
      if (col_out !== 8'hFF) begin
         failures++;
         $display("FAIL row0_data got=%h exp=ff", col_out);
      end
      goto_pos(44);
      checks++;
      if (col_out !== 8'h81 || row_sel !== 8'h80) begin
         failures++;
         $display("FAIL row7_data got=%h/%h exp=81/80", col_out, row_sel);
      end
   endtask

   task automatic test_two_strobes();
      logic seen01;
      goto_pos(3);
      strobe(64'h1);
      goto_pos(20);
      strobe(64'h2);
      seen01 = 1'b0;
      while ((cyc % 48) != 6) begin
         if (col_out === 8'h01) seen01 = 1'b1;
         if ((cyc % 48) == 2) begin
            checks++;
            if (col_out !== 8'h02) begin
               failures++;
               $display("FAIL last_strobe_wins got=%h exp=02", col_out);
            end
         end
         step();
      end
      checks++;
      if (seen01) begin
         failures++;
         $display("FAIL stale_strobe got=01 exp=never");
      end
   endtask

   task automatic test_boundary_strobe();
      goto_pos(47);
      strobe(64'h3C);
      checks++;
      if (gif.pending !== 1'b0 || frame_done !== 1'b1) begin
         failures++;
         $display("FAIL bypass_pending got=%b/%b exp=0/1", gif.pending, frame_done);
      end
      goto_pos(2);
      checks++;
      if (col_out !== 8'h3C || gif.pending !== 1'b0) begin
         failures++;
         $display("FAIL bypass_data got=%h/%b exp=3c/0", col_out, gif.pending);
      end
   endtask

   task automatic test_enable();
      goto_pos(20);
      enable = 1'b0; #1;
      checks++;
      if (row_sel !== 8'h00 || col_out !== 8'h00) begin
         failures++;
         $display("FAIL disable_dark got=%h/%h exp=00/00", row_sel, col_out);
      end
      step();
      checks++;
      if (row_idx !== 3'd3 || frame_done !== 1'b0 || row_sel !== 8'h00) begin
         failures++;
         $display("FAIL disable_hold got=%0d/%b/%h exp=3/0/00",
                  row_idx, frame_done, row_sel);
      end
      strobe(64'h0000_0000_A500_0000);
      checks++;
      if (gif.pending !== 1'b0 || row_sel !== 8'h00) begin
         failures++;
         $display("FAIL dark_transfer got=%b/%h exp=0/00", gif.pending, row_sel);
      end
      step();
      enable = 1'b1; #1; cyc = 18;
      checks++;
      if (row_sel !== 8'h08 || col_out !== 8'h00) begin
         failures++;
         $display("FAIL resume_blank0 got=%h/%h exp=08/00", row_sel, col_out);
      end
      step();
      checks++;
      if (col_out !== 8'h00) begin
         failures++;
         $display("FAIL resume_blank1 got=%h exp=00", col_out);
      end
      step();
      checks++;
      if (col_out !== 8'hA5 || row_sel !== 8'h08) begin
         failures++;
         $display("FAIL resume_data got=%h/%h exp=a5/08", col_out, row_sel);
      end
   endtask

   task automatic test_reset_midframe();
      logic early;
      goto_pos(25);
      strobe(64'hFFFF_FFFF_FFFF_FFFF);
      goto_pos(32);
      checks++;
      if (row_idx !== 3'd5 || gif.pending !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset got=%0d/%b exp=5/1", row_idx, gif.pending);
      end
      reset = 1'b1;
      step();
      checks++;
      if (row_idx !== 3'd0 || col_out !== 8'h00 || gif.pending !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got=%0d/%h/%b exp=0/00/0",
                  row_idx, col_out, gif.pending);
      end
      reset = 1'b0; #1; cyc = 0;
      checks++;
      if (row_sel !== 8'h01 || col_out !== 8'h00) begin
         failures++;
         $display("FAIL restart_row0 got=%h/%h exp=01/00", row_sel, col_out);
      end
      early = 1'b0;
      while (cyc < 48) begin
         if (frame_done !== 1'b0) early = 1'b1;
         step();
      end
      checks++;
      if (early) begin
         failures++;
         $display("FAIL restart_frame_done got=1 exp=0");
      end
      goto_pos(2);
      checks++;
      if (col_out !== 8'h00) begin
         failures++;
         $display("FAIL buffers_cleared got=%h exp=00", col_out);
      end
   endtask

   initial begin
      test_reset();
      test_frame_done();
      test_midframe();
      test_two_strobes();
      test_boundary_strobe();
      test_enable();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
